// File: rtl/fpu_cvt16_result_buffer.sv
// Result buffer behind the 16-bit convert stage: NaN-boxes half results, queues them in order
// and accumulates sticky exception flags. Optional macro: FPU_CVT16_CANON_NAN_EN.
module fpu_cvt16_result_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      cvt_out,
    input  logic             res_is_half,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [4:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       fflags,
    input  logic             fflags_clr
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;
    logic [31:0]   stored_word;

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        stored_word = cvt_out;
        if (res_is_half) begin
            stored_word = {16'hFFFF, cvt_out[15:0]};
`ifdef FPU_CVT16_CANON_NAN_EN
            if ((cvt_out[14:10] == 5'h1F) && (cvt_out[9:0] != '0)) begin
                stored_word = 32'hFFFF_7E00;
            end
`endif
        end
    end

    // Storage is deliberately not reset; only the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[wr_ptr] <= stored_word;
            tag_mem[wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Clear applies before the same-cycle accept, so a cleared accept leaves just its own flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fflags <= '0;
        end else if (fflags_clr) begin
            fflags <= push ? in_flags : '0;
        end else if (push) begin
            fflags <= fflags | in_flags;
        end
    end

    assign out_data = data_mem[rd_ptr];
    assign out_tag  = tag_mem[rd_ptr];

endmodule

// File: tb/tb_fpu_cvt16_result_buffer.sv
// Scoreboard bench for fpu_cvt16_result_buffer: expected entries queued at accept, compared at the head.
module tb_fpu_cvt16_result_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] cvt_out;
    logic        res_is_half;
    logic [4:0]  in_tag;
    logic [4:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [4:0]  fflags;
    logic        fflags_clr;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  exp_flags;
    int          n_tests = 0;
    int          n_fail  = 0;

    fpu_cvt16_result_buffer #(.DEPTH(4), .TAG_W(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cvt_out    (cvt_out),
        .res_is_half(res_is_half),
        .in_tag     (in_tag),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .fflags     (fflags),
        .fflags_clr (fflags_clr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] d, input logic half);
        logic [31:0] w;
        w = d;
        if (half) begin
            w = {16'hFFFF, d[15:0]};
`ifdef FPU_CVT16_CANON_NAN_EN
            if (d[14:10] == 5'h1F && d[9:0] != 10'd0) w = 32'hFFFF_7E00;
`endif
        end
        return w;
    endfunction

    // One clock: check outputs against the model mid-cycle, advance the model, then cross the edge.
    task automatic step();
        logic exp_rdy;
        logic exp_vld;
        logic acc;
        ent_t e;
        @(negedge CLK);
        exp_rdy = (q.size() < 4);
        exp_vld = (q.size() != 0);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
        check("fflags", {27'd0, fflags}, {27'd0, exp_flags});
        if (exp_vld) begin
            check("out_data", out_data, q[0].d);
            check("out_tag", {27'd0, out_tag}, {27'd0, q[0].t});
        end
        acc = in_valid && exp_rdy;
        if (RST) begin
            q.delete();
            exp_flags = '0;
        end else begin
            if (exp_vld && out_ready) void'(q.pop_front());
            if (acc) begin
                e.d = exp_word(cvt_out, res_is_half);
                e.t = in_tag;
                q.push_back(e);
            end
            if (fflags_clr) exp_flags = acc ? in_flags : 5'd0;
            else if (acc)   exp_flags = exp_flags | in_flags;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic h,
                         input logic [4:0] t, input logic [4:0] f);
        in_valid    = v;
        cvt_out     = d;
        res_is_half = h;
        in_tag      = t;
        in_flags    = f;
    endtask

    initial begin
        RST = 1'b1; out_ready = 1'b0; fflags_clr = 1'b0;
        exp_flags = '0;
        drive(1'b0, '0, 1'b0, '0, '0);
        step(); step();
        RST = 1'b0;
        step();

        // Single half result, latency one cycle
        drive(1'b1, 32'h0000_3C00, 1'b1, 5'd3, 5'd0);
        step();
        drive(1'b0, '0, 1'b0, '0, '0);
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_data", out_data, 32'hFFFF_3C00);
        check("first_tag", {27'd0, out_tag}, 32'd3);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Fill to full, offer while full, then drain
        for (int unsigned i = 1; i <= 4; i++) begin
            drive(1'b1, i, 1'b0, 5'(i), 5'd0);
            step();
        end
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'd99, 1'b0, 5'd9, 5'd0);
        step(); step();
        drive(1'b0, '0, 1'b0, '0, '0);
        check("stall_data", out_data, 32'd1);
        out_ready = 1'b1;
        step();
        check("ready_after_pop", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) step();

        // Streaming push+pop, pointers wrap
        for (int unsigned i = 0; i < 10; i++) begin
            drive(1'b1, 32'h1234_0100 + i, i[0], 5'(i + 10), 5'd0);
            step();
            if (i > 0) check("stream_count1", {31'd0, out_valid & in_ready}, 32'd1);
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        step(); step();

        // Sticky flags and clear-with-accept
        drive(1'b1, 32'd5, 1'b0, 5'd1, 5'b10000); step();
        drive(1'b1, 32'd6, 1'b0, 5'd2, 5'b00001); step();
        drive(1'b0, '0, 1'b0, '0, '0);
        check("flags_or", {27'd0, fflags}, 32'b10001);
        fflags_clr = 1'b1;
        drive(1'b1, 32'd7, 1'b0, 5'd3, 5'b00100); step();
        fflags_clr = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0);
        check("flags_clr_set", {27'd0, fflags}, 32'b00100);
        fflags_clr = 1'b1; step();
        fflags_clr = 1'b0;
        check("flags_clr", {27'd0, fflags}, 32'd0);
        step();

        // NaN payload handling
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_7C01, 1'b1, 5'd4, 5'd0); step();
        drive(1'b0, '0, 1'b0, '0, '0);
`ifdef FPU_CVT16_CANON_NAN_EN
        check("nan_data", out_data, 32'hFFFF_7E00);
`else
        check("nan_data", out_data, 32'hFFFF_7C01);
`endif
        out_ready = 1'b1; step(); step();

        // Reset mid-push discards queued entries
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA0 + i, 1'b0, 5'(i), 5'b01000); step();
        end
        RST = 1'b1;
        drive(1'b1, 32'hBAD, 1'b0, 5'd7, 5'b00010); step();
        RST = 1'b0;
        drive(1'b0, '0, 1'b0, '0, '0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_fflags", {27'd0, fflags}, 32'd0);
        drive(1'b1, 32'h0000_ABCD, 1'b0, 5'd21, 5'd0); step();
        drive(1'b0, '0, 1'b0, '0, '0);
        check("post_rst_head", out_data, 32'h0000_ABCD);
        out_ready = 1'b1; step(); step();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                  5'($urandom), 5'($urandom));
            out_ready  = ($urandom_range(0, 2) != 0);
            fflags_clr = ($urandom_range(0, 7) == 0);
            step();
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        fflags_clr = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 6; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
